// File: rtl/fp_divsqrt_scheduler_if.sv
// Handshake bundle between EX/ID/WB and the shared FDIV/FSQRT scheduler.
// The master drives issue/ID/WB requests, and the slave is the scheduler.
interface fp_divsqrt_scheduler_if;
    logic       issue_valid;
    logic       issue_is_sqrt;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       ex_hold;
    logic       unit_start;

    logic [4:0] id_fp_rs1;
    logic [4:0] id_fp_rs2;
    logic [4:0] id_fp_rs3;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_uses_rs3;
    logic [4:0] id_fp_rd;
    logic       id_fp_reg_write;
    logic       stall_out;

    logic       wb_pipe_fp_reg_write;
    logic       wb_sel;
    logic [4:0] wb_rd;

    modport master (
        output issue_valid, issue_is_sqrt, issue_rd,
        output id_fp_rs1, id_fp_rs2, id_fp_rs3,
        output id_uses_rs1, id_uses_rs2, id_uses_rs3,
        output id_fp_rd, id_fp_reg_write, wb_pipe_fp_reg_write,
        input  issue_ready, ex_hold, unit_start, stall_out, wb_sel, wb_rd
    );

    modport slave (
        input  issue_valid, issue_is_sqrt, issue_rd,
        input  id_fp_rs1, id_fp_rs2, id_fp_rs3,
        input  id_uses_rs1, id_uses_rs2, id_uses_rs3,
        input  id_fp_rd, id_fp_reg_write, wb_pipe_fp_reg_write,
        output issue_ready, ex_hold, unit_start, stall_out, wb_sel, wb_rd
    );
endinterface

// File: rtl/fp_divsqrt_scheduler.sv
// Issue/latency/scoreboard controller for the shared FDIV.S/FSQRT.S unit.
// This controller arbitrates the FP write port, with priority to pipelined WB. Both latencies must be >= 2.
module fp_divsqrt_scheduler #(
    parameter int DIV_LATENCY  = 16,
    parameter int SQRT_LATENCY = 20
) (
    input logic                    clk,
    input logic                    rst,
    fp_divsqrt_scheduler_if.slave  bus
);
    localparam int MAX_LAT = (DIV_LATENCY > SQRT_LATENCY) ? DIV_LATENCY : SQRT_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] SQRT_CNT = CNT_W'(SQRT_LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       busy_rd_q, busy_rd_d;
    logic             first_q, first_d;
    logic             wb_sel_c;
    logic             accept;
    logic             busy;
    logic             rd_hit;

    assign accept = bus.issue_valid && (state_q == S_IDLE);
    assign busy   = (state_q != S_IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_rd_d = busy_rd_q;
        first_d   = 1'b0;
        wb_sel_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_BUSY;
                    busy_rd_d = bus.issue_rd;
                    cnt_d     = bus.issue_is_sqrt ? SQRT_CNT : DIV_CNT;
                    first_d   = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!bus.wb_pipe_fp_reg_write) begin
                    wb_sel_c = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.wb_pipe_fp_reg_write) begin
                    wb_sel_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_rd_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_rd_q <= busy_rd_d;
            first_q   <= first_d;
        end
    end

    // f0 is an ordinary destination, so register 0 is deliberately not excluded.
    assign rd_hit = (bus.id_uses_rs1 && (bus.id_fp_rs1 == busy_rd_q)) ||
                    (bus.id_uses_rs2 && (bus.id_fp_rs2 == busy_rd_q)) ||
                    (bus.id_uses_rs3 && (bus.id_fp_rs3 == busy_rd_q)) ||
                    (bus.id_fp_reg_write && (bus.id_fp_rd == busy_rd_q));

    assign bus.issue_ready = !busy;
    assign bus.ex_hold     = bus.issue_valid && busy;
    assign bus.unit_start  = first_q;
    assign bus.wb_sel      = wb_sel_c;
    assign bus.wb_rd       = busy_rd_q;
    // HOLD stalls unconditionally so the pipelined WB drains and the result gets the port.
    assign bus.stall_out   = (busy && rd_hit) || (state_q == S_HOLD);
endmodule

// File: tb/tb_fp_divsqrt_scheduler.sv
// Self-checking bench: a cycle-numbered reference model checks outputs every cycle.
// A scoreboard queue pairs each accepted issue with the div/sqrt write that retires it.
module tb_fp_divsqrt_scheduler;
    localparam int DIV_L  = 16;
    localparam int SQRT_L = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_divsqrt_scheduler_if bus();

    fp_divsqrt_scheduler #(
        .DIV_LATENCY (DIV_L),
        .SQRT_LATENCY(SQRT_L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0] rd;
        int         ready_cyc;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    // Model state: one pending operation, described by cycle numbers.
    bit         m_pending;
    logic [4:0] m_rd;
    int         m_ready;
    int         m_start;
    bit         pipe_hist[0:8191];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit hazard(input logic [4:0] rd);
        return (bus.id_uses_rs1 && bus.id_fp_rs1 == rd) ||
               (bus.id_uses_rs2 && bus.id_fp_rs2 == rd) ||
               (bus.id_uses_rs3 && bus.id_fp_rs3 == rd) ||
               (bus.id_fp_reg_write && bus.id_fp_rd == rd);
    endfunction

    // Check the current cycle at the falling edge, advance the model, then step to the next cycle.
    task automatic tick();
        bit wsel;
        bit hold;
        @(negedge clk);
        pipe_hist[cyc % 8192] = bus.wb_pipe_fp_reg_write;
        if (rst) begin
            m_pending = 1'b0;
            m_rd      = 5'd0;
            sb_q.delete();
        end else begin
            hold = m_pending && (cyc > m_ready);
            wsel = m_pending && (cyc >= m_ready) && !bus.wb_pipe_fp_reg_write;
            check("issue_ready", bus.issue_ready, !m_pending);
            check("ex_hold", bus.ex_hold, bus.issue_valid && m_pending);
            check("unit_start", bus.unit_start, m_pending && (cyc == m_start));
            check("wb_sel", bus.wb_sel, wsel);
            check("wb_rd", bus.wb_rd, m_rd);
            check("stall_out", bus.stall_out, (m_pending && hazard(m_rd)) || hold);
            if (wsel) begin
                m_pending = 1'b0;
            end else if (!m_pending && bus.issue_valid) begin
                m_pending = 1'b1;
                m_rd      = bus.issue_rd;
                m_start   = cyc + 1;
                m_ready   = cyc + (bus.issue_is_sqrt ? SQRT_L : DIV_L);
                sb_q.push_back('{rd: bus.issue_rd, ready_cyc: m_ready});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet_inputs();
        bus.issue_valid          = 1'b0;
        bus.issue_is_sqrt        = 1'b0;
        bus.issue_rd             = 5'd0;
        bus.id_fp_rs1            = 5'd0;
        bus.id_fp_rs2            = 5'd0;
        bus.id_fp_rs3            = 5'd0;
        bus.id_uses_rs1          = 1'b0;
        bus.id_uses_rs2          = 1'b0;
        bus.id_uses_rs3          = 1'b0;
        bus.id_fp_rd             = 5'd0;
        bus.id_fp_reg_write      = 1'b0;
        bus.wb_pipe_fp_reg_write = 1'b0;
    endtask

    task automatic issue_one(input bit sqrt, input logic [4:0] rd);
        bus.issue_valid   = 1'b1;
        bus.issue_is_sqrt = sqrt;
        bus.issue_rd      = rd;
        tick();
        bus.issue_valid   = 1'b0;
    endtask

    // Scoreboard monitor: each div/sqrt write must retire the oldest accepted issue.
    always @(negedge clk) begin
        if (!rst && bus.wb_sel === 1'b1) begin
            check("wb_port_conflict", bus.wb_pipe_fp_reg_write, 1'b0);
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                sb_t e;
                bit  denied_all;
                e = sb_q.pop_front();
                check("sb_wb_rd", bus.wb_rd, e.rd);
                check("sb_not_early", cyc >= e.ready_cyc, 1'b1);
                denied_all = 1'b1;
                for (int c = e.ready_cyc; c < cyc; c++)
                    if (!pipe_hist[c % 8192]) denied_all = 1'b0;
                check("sb_not_late", denied_all, 1'b1);
            end
        end
    end

    initial begin
        quiet_inputs();
        rst = 1'b1;
        m_pending = 1'b0;
        m_rd = 5'd0;
        run(3);
        rst = 1'b0;
        run(3);

        // FDIV to f0 with and without a RAW reader of f0 in ID.
        bus.id_uses_rs2 = 1'b1;
        bus.id_fp_rs2   = 5'd0;
        issue_one(1'b0, 5'd0);
        run(20);
        bus.id_uses_rs2 = 1'b0;
        issue_one(1'b0, 5'd0);
        run(20);

        // WAW on f7, then a non-conflicting f8 destination.
        bus.id_fp_reg_write = 1'b1;
        bus.id_fp_rd        = 5'd7;
        issue_one(1'b0, 5'd7);
        run(5);
        bus.id_fp_rd = 5'd8;
        run(15);
        bus.id_fp_reg_write = 1'b0;

        // Write-port conflict in the two cycles the result first becomes ready.
        issue_one(1'b0, 5'd3);
        run(15);
        bus.wb_pipe_fp_reg_write = 1'b1;
        run(2);
        bus.wb_pipe_fp_reg_write = 1'b0;
        run(5);

        // FSQRT with a second issue held valid behind it.
        bus.issue_valid   = 1'b1;
        bus.issue_is_sqrt = 1'b1;
        bus.issue_rd      = 5'd5;
        run(40);
        bus.issue_valid = 1'b0;
        run(25);

        // Reset during an in-flight FDIV abandons it.
        bus.id_uses_rs1 = 1'b1;
        bus.id_fp_rs1   = 5'd9;
        issue_one(1'b0, 5'd9);
        run(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(25);
        quiet_inputs();

        // Randomized traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            bus.issue_valid          = ($urandom_range(0, 9) < 3);
            bus.issue_is_sqrt        = $urandom_range(0, 1);
            bus.issue_rd             = 5'($urandom_range(0, 3));
            bus.id_fp_rs1            = 5'($urandom_range(0, 3));
            bus.id_fp_rs2            = 5'($urandom_range(0, 3));
            bus.id_fp_rs3            = 5'($urandom_range(0, 31));
            bus.id_uses_rs1          = $urandom_range(0, 1);
            bus.id_uses_rs2          = $urandom_range(0, 1);
            bus.id_uses_rs3          = $urandom_range(0, 1);
            bus.id_fp_rd             = 5'($urandom_range(0, 3));
            bus.id_fp_reg_write      = $urandom_range(0, 1);
            bus.wb_pipe_fp_reg_write = ($urandom_range(0, 9) < 6);
            rst                      = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        // Drain: every accepted operation must have been written back.
        quiet_inputs();
        run(30);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
